// File: rtl/decode_stage_hz_pkg.sv
// Shared decode definitions: opcodes, control-field bit positions, widths
// and the main control decode function.
package decode_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 6;
    localparam int WB_W     = 2;
    localparam int MEM_W    = 3;
    localparam int EX_W     = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int MEM_BRANCH   = 2;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;
    localparam int EX_REGDST    = 3;
    localparam int EX_ALUSRC    = 0;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
        logic             illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [OPCODE_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin c.wb = 2'b10; c.ex = 4'b1100; end
            OP_LW:    begin c.wb = 2'b11; c.mem = 3'b010; c.ex = 4'b0001; end
            OP_SW:    begin c.mem = 3'b001; c.ex = 4'b0001; end
            OP_BEQ:   begin c.mem = 3'b100; c.ex = 4'b0010; end
            OP_ADDI:  begin c.wb = 2'b10; c.ex = 4'b0001; end
            default:  c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Opcodes whose rt field is a source operand (not a destination).
    function automatic logic reads_rt(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/decode_stage_hz_if.sv
// ID/EX pipeline latch bundle: decode stage drives it, execute stage reads it.
interface decode_stage_hz_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    import decode_pkg::*;

    logic               id_ex_valid;
    logic [WB_W-1:0]    id_ex_wb;
    logic [MEM_W-1:0]   id_ex_mem;
    logic [EX_W-1:0]    id_ex_execute;
    logic [DATA_W-1:0]  id_ex_npc;
    logic [DATA_W-1:0]  id_ex_readdat1;
    logic [DATA_W-1:0]  id_ex_readdat2;
    logic [DATA_W-1:0]  id_ex_sign_ext;
    logic [REG_AW-1:0]  id_ex_rs;
    logic [REG_AW-1:0]  id_ex_instr_bits_20_16;
    logic [REG_AW-1:0]  id_ex_instr_bits_15_11;
    logic [FUNCT_W-1:0] id_ex_instr_funct;
    logic               id_ex_illegal;

    modport master (
        output id_ex_valid, id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc,
               id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext, id_ex_rs,
               id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
               id_ex_instr_funct, id_ex_illegal
    );

    modport slave (
        input id_ex_valid, id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc,
              id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext, id_ex_rs,
              id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
              id_ex_instr_funct, id_ex_illegal
    );

endinterface

// File: rtl/decode_stage_hz_regfile_bypass.sv
// Register file with hardwired r0, synchronous clear and optional
// write-before-read bypass from the WB port.
module regfile_bypass #(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 32,
    parameter int WB_BYPASS = 1,
    localparam int REG_AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if ((WB_BYPASS != 0) && we && (waddr == raddr1)) rdata1 = wdata;
        if ((WB_BYPASS != 0) && we && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage_hz.sv
// MIPS instruction-decode stage: register file, control decode, load-use
// hazard detection and the ID/EX latch with flush/hold handling.
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 32,
    parameter int WB_BYPASS = 1,
    localparam int REG_AW   = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] if_id_instr,
    input  logic [DATA_W-1:0]  if_id_npc,
    input  logic               if_id_valid,
    input  logic               wb_reg_write,
    input  logic [REG_AW-1:0]  wb_write_reg_location,
    input  logic [DATA_W-1:0]  mem_wb_write_data,
    input  logic               ex_flush,
    input  logic               ex_hold,
    output logic               id_stall,
    decode_stage_hz_if.master  id_ex
);

    logic [OPCODE_W-1:0] opcode;
    logic [REG_AW-1:0]   rs, rt, rd;
    logic [DATA_W-1:0]   rd1, rd2, sign_ext;
    ctrl_t               ctrl;
    logic                hazard;

    assign opcode   = if_id_instr[31:26];
    assign rs       = if_id_instr[21 +: REG_AW];
    assign rt       = if_id_instr[16 +: REG_AW];
    assign rd       = if_id_instr[11 +: REG_AW];
    assign sign_ext = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
    assign ctrl     = decode_ctrl(opcode);

    regfile_bypass #(
        .DATA_W    (DATA_W),
        .NREGS     (NREGS),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_reg_write),
        .waddr  (wb_write_reg_location),
        .wdata  (mem_wb_write_data),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_comb begin
        hazard = id_ex.id_ex_valid && id_ex.id_ex_mem[MEM_MEMREAD]
              && (id_ex.id_ex_instr_bits_20_16 != '0) && if_id_valid
              && ((id_ex.id_ex_instr_bits_20_16 == rs)
                  || (reads_rt(opcode) && (id_ex.id_ex_instr_bits_20_16 == rt)));
    end

    assign id_stall = (hazard | ex_hold) & ~ex_flush;

    // Reset, flush and the load-use bubble all load an all-zero latch.
    always_ff @(posedge clk) begin
        if (rst || ex_flush || (hazard && !ex_hold)) begin
            id_ex.id_ex_valid            <= 1'b0;
            id_ex.id_ex_wb               <= '0;
            id_ex.id_ex_mem              <= '0;
            id_ex.id_ex_execute          <= '0;
            id_ex.id_ex_illegal          <= 1'b0;
            id_ex.id_ex_npc              <= '0;
            id_ex.id_ex_readdat1         <= '0;
            id_ex.id_ex_readdat2         <= '0;
            id_ex.id_ex_sign_ext         <= '0;
            id_ex.id_ex_rs               <= '0;
            id_ex.id_ex_instr_bits_20_16 <= '0;
            id_ex.id_ex_instr_bits_15_11 <= '0;
            id_ex.id_ex_instr_funct      <= '0;
        end else if (!ex_hold) begin
            id_ex.id_ex_valid            <= if_id_valid;
            id_ex.id_ex_wb               <= if_id_valid ? ctrl.wb      : '0;
            id_ex.id_ex_mem              <= if_id_valid ? ctrl.mem     : '0;
            id_ex.id_ex_execute          <= if_id_valid ? ctrl.ex      : '0;
            id_ex.id_ex_illegal          <= if_id_valid ? ctrl.illegal : 1'b0;
            id_ex.id_ex_npc              <= if_id_npc;
            id_ex.id_ex_readdat1         <= rd1;
            id_ex.id_ex_readdat2         <= rd2;
            id_ex.id_ex_sign_ext         <= sign_ext;
            id_ex.id_ex_rs               <= rs;
            id_ex.id_ex_instr_bits_20_16 <= rt;
            id_ex.id_ex_instr_bits_15_11 <= rd;
            id_ex.id_ex_instr_funct      <= if_id_instr[FUNCT_W-1:0];
        end
    end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised next-generation instruction-decode stage for the 5-stage MIPS pipeline.
- Contains the register file, the main control decode and the ID/EX pipeline latch.
- Adds three things the first-generation decode stage lacks:
  - write-before-read bypass from WB;
  - load-use hazard detection with automatic stall and bubble insertion;
  - flush and hold handshakes with a valid bit.
- Sits between the IF/ID latch and the execute stage.

Parameters:
- DATA_W, 32, datapath and register width in bits.
- NREGS, 32, register count (power of two, ≥2); REG_AW = $clog2(NREGS).
- WB_BYPASS, 1, 1 = same-cycle WB write is visible to ID read; 0 = register file read only.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_id_instr  in  32  instruction from IF/ID.
- if_id_npc  in  DATA_W  next PC from IF/ID.
- if_id_valid  in  1  IF/ID holds a real instruction.
- wb_reg_write  in  1  write enable from MEM/WB.
- wb_write_reg_location  in  REG_AW  write register number.
- mem_wb_write_data  in  DATA_W  write data.
- ex_flush  in  1  branch taken; kill the instruction currently in ID.
- ex_hold  in  1  downstream not ready; freeze ID/EX.
- id_stall  out  1  to IF: hold PC and IF/ID this cycle (combinational).
- id_ex_valid  out  1  ID/EX contents are a real instruction.
- id_ex_wb  out  2  {RegWrite, MemtoReg}.
- id_ex_mem  out  3  {Branch, MemRead, MemWrite}.
- id_ex_execute  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext  out  DATA_W each.
- id_ex_rs, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11  out  REG_AW each.
- id_ex_instr_funct  out  6  instruction bits [5:0].
- id_ex_illegal  out  1  undecodable opcode latched.

Behaviour:
- Register file:
  - NREGS x DATA_W; written on clk rising edge when wb_reg_write=1 and location≠0.
  - r0 always reads 0.
  - rst clears all registers to 0.
  - Reads are combinational on instr[25:21] (rs) and instr[20:16] (rt).
  - With WB_BYPASS=1, a read of a nonzero register being written this cycle returns mem_wb_write_data.
- Sign extend: instr[15:0] sign-extended to DATA_W.
- Control decode (combinational on instr[31:26]), wb/mem/ex:
  - R-type 0x00 → 10/000/1100.
  - lw 0x23 → 11/010/0001.
  - sw 0x2B → 00/001/0001.
  - beq 0x04 → 00/100/0010.
  - addi 0x08 → 10/000/0001.
  - Any other opcode → all zero, illegal=1.
- Load-use hazard (combinational), all of the following must hold:
  - id_ex_valid=1 and id_ex_mem[MemRead]=1;
  - id_ex_instr_bits_20_16 ≠ 0;
  - it equals instr rs, or equals instr rt for R-type/sw/beq;
  - if_id_valid=1.
- Latch update priority, evaluated at each rising edge:
  1. rst: every output register ← 0; id_ex_valid ← 0.
  2. ex_flush: load a bubble (all control, valid and illegal ← 0; data fields don't-care, driven 0).
  3. ex_hold: all ID/EX registers retain their values.
  4. hazard: load a bubble.
  5. Otherwise:
     - load the decoded instruction;
     - valid ← if_id_valid;
     - control forced to 0 when if_id_valid=0.
- id_stall = (hazard | ex_hold) & ~ex_flush.
  - A hazard stall lasts exactly 1 cycle, because the bubble clears MemRead.
- Latency: 1 cycle from IF/ID to ID/EX.
- Simultaneous events:
  - WB write and read of the same register with WB_BYPASS=0: ID/EX captures the old value. The pipeline then requires a forwarding unit in EX.
  - flush during hold: the flush wins and the bubble is loaded.
  - rst during a stall: id_stall=0 from the next cycle; the register file is cleared.

Decomposition:
- Package decode_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - control bit index constants: WB_REGWRITE, WB_MEMTOREG, MEM_BRANCH, MEM_MEMREAD, MEM_MEMWRITE, EX_REGDST, EX_ALUSRC;
  - field widths.
- One natural sub-module: regfile_bypass. It is parametrised by DATA_W, NREGS and WB_BYPASS, and contains the storage, r0 handling and bypass mux.
- Control decode, hazard logic and the ID/EX latch stay inline.

Test Plan:
- Reset, then read r5 → id_ex_readdat1=0, id_ex_valid=0; all control 0.
- WB writes r3=0xDEADBEEF while ID decodes add r4,r3,r0 (WB_BYPASS=1) → next cycle id_ex_readdat1=0xDEADBEEF. With WB_BYPASS=0 → old value 0.
- lw r2,0(r1) followed by add r5,r2,r2:
  - id_stall=1 for exactly 1 cycle;
  - ID/EX holds a bubble with valid=0;
  - the add reaches ID/EX on the following cycle with valid=1, ex=1100.
- ex_flush asserted with beq in ID → ID/EX valid=0, id_ex_mem=000; id_stall=0 even if a hazard condition is present.
- ex_hold for 3 cycles → ID/EX fields unchanged and id_stall=1 throughout; next instruction loads the cycle after hold drops.
- Opcode 0x3F → id_ex_illegal=1, all control 0. Also check a write to r0 of 0x1234 → r0 still reads 0.
